// File: rtl/jtag_clk_rst_pkg.sv
// Shared types and constants for the JTAG clock/reset controller.
// Optional build macro: JTAG_SAMPLE_NEGEDGE_EN (selects TDO sampling edge).
package jtag_clk_rst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    TRST,
    TLR_EXIT,
    DONE
  } jtag_state_e;

  localparam int unsigned TrstPeriods = 5;
  localparam int unsigned DefMaxLen   = 64;

  function automatic logic [7:0] eff_len(
    input logic [6:0]  len,
    input int unsigned max_len
  );
    if (32'(len) > max_len) return 8'(max_len);
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/jtag_tck_div.sv
// Free-running TCK divider with one-cycle strobes marking the
// cycle whose closing edge makes TCK fall or rise.
module jtag_tck_div #(
  parameter int unsigned TckHalfCycles = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tck_o,
  output logic fall_stb_o,
  output logic rise_stb_o
);

  localparam int unsigned CntW =
    (TckHalfCycles > 1) ? $clog2(TckHalfCycles) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tck_q, tck_d;
  logic            wrap;

  assign wrap = (cnt_q == CntW'(TckHalfCycles - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    tck_d = tck_q;
    if (wrap) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o      = tck_q;
  assign fall_stb_o = ~rst_i & wrap & tck_q;
  assign rise_stb_o = ~rst_i & wrap & ~tck_q;

endmodule

// File: rtl/jtag_clk_rst_ctrl.sv
// JTAG master: reset stretcher, TCK generation and shift/TAP-reset engine.
// Define JTAG_SAMPLE_NEGEDGE_EN to sample TDO on TCK fall instead of rise.
module jtag_clk_rst_ctrl
  import jtag_clk_rst_pkg::*;
#(
  parameter int unsigned RstClkCycles  = 5,
  parameter int unsigned TckHalfCycles = 1,
  parameter int unsigned MaxLen        = DefMaxLen
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              rst_no,
  output logic              tck_o,
  output logic              trst_no,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_reset_i,
  input  logic [6:0]        req_len_i,
  input  logic [MaxLen-1:0] req_tms_i,
  input  logic [MaxLen-1:0] req_tdi_i,
  output logic              rsp_valid_o,
  output logic [MaxLen-1:0] rsp_tdo_o
);

  localparam int unsigned RstW = $clog2(RstClkCycles + 1);
  localparam int unsigned IdxW = $clog2(MaxLen);

  logic [RstW-1:0] rcnt_q;
  logic            rst_no_q;
  logic            core_rst;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rcnt_q   <= '0;
      rst_no_q <= 1'b0;
    end else if (!rst_no_q) begin
      if (rcnt_q == RstW'(RstClkCycles - 1)) rst_no_q <= 1'b1;
      else rcnt_q <= rcnt_q + RstW'(1);
    end
  end

  assign core_rst = rst_i | ~rst_no_q;

  logic fall_stb, rise_stb;

  jtag_tck_div #(
    .TckHalfCycles(TckHalfCycles)
  ) u_div (
    .clk_i     (clk_i),
    .rst_i     (core_rst),
    .tck_o     (tck_o),
    .fall_stb_o(fall_stb),
    .rise_stb_o(rise_stb)
  );

  jtag_state_e       state_q, state_d;
  logic [7:0]        bit_q, bit_d, len_q, len_d, prev_bit;
  logic [MaxLen-1:0] tmsv_q, tmsv_d, tdiv_q, tdiv_d;
  logic [MaxLen-1:0] rsp_q, rsp_d;
  logic              tms_q, tms_d, tdi_q, tdi_d;
  logic              trst_q, trst_d;
  logic              smp_stb;

  assign prev_bit    = bit_q - 8'd1;
  assign req_ready_o = (state_q == IDLE) & rst_no_q;
`ifdef JTAG_SAMPLE_NEGEDGE_EN
  assign smp_stb = fall_stb;
`else
  assign smp_stb = rise_stb;
`endif

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    len_d   = len_q;
    tmsv_d  = tmsv_q;
    tdiv_d  = tdiv_q;
    rsp_d   = rsp_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    trst_d  = trst_q;
    unique case (state_q)
      IDLE: begin
        tms_d  = 1'b0;
        tdi_d  = 1'b0;
        trst_d = 1'b0;
        if (req_valid_i && req_ready_o) begin
          tmsv_d = req_tms_i;
          tdiv_d = req_tdi_i;
          len_d  = eff_len(req_len_i, MaxLen);
          rsp_d  = '0;
          bit_d  = '0;
          if (req_reset_i)        state_d = TRST;
          else if (len_d == 8'd0) state_d = DONE;
          else                    state_d = SHIFT;
        end
      end
      SHIFT: begin
        // bit_q counts bits driven; the one on the wire is bit_q-1
        if (smp_stb && bit_q != 8'd0)
          rsp_d[prev_bit[IdxW-1:0]] = tdo_i;
        if (fall_stb) begin
          if (bit_q < len_q) begin
            tms_d = tmsv_q[bit_q[IdxW-1:0]];
            tdi_d = tdiv_q[bit_q[IdxW-1:0]];
            bit_d = bit_q + 8'd1;
          end else begin
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      TRST: begin
        if (fall_stb) begin
          if (bit_q == 8'(TrstPeriods)) begin
            trst_d  = 1'b0;
            tms_d   = 1'b0;
            state_d = TLR_EXIT;
          end else begin
            trst_d = 1'b1;
            tms_d  = 1'b1;
            bit_d  = bit_q + 8'd1;
          end
        end
      end
      TLR_EXIT: begin
        if (fall_stb) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (core_rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      len_q   <= '0;
      tmsv_q  <= '0;
      tdiv_q  <= '0;
      rsp_q   <= '0;
      tms_q   <= 1'b0;
      tdi_q   <= 1'b0;
      trst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      tmsv_q  <= tmsv_d;
      tdiv_q  <= tdiv_d;
      rsp_q   <= rsp_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      trst_q  <= trst_d;
    end
  end

  assign rst_no      = rst_no_q;
  assign trst_no     = rst_no_q & ~trst_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;
  assign rsp_valid_o = (state_q == DONE);
  assign rsp_tdo_o   = rsp_q;

endmodule

// File: tb/tb_jtag_clk_rst_ctrl.sv
// Directed + randomized bench for jtag_clk_rst_ctrl with TDO looped to TDI.
module tb_jtag_clk_rst_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rst_no, tck_o, trst_no, tms_o, tdi_o, tdo_i;
  logic        req_valid_i, req_ready_o, req_reset_i;
  logic [6:0]  req_len_i;
  logic [63:0] req_tms_i, req_tdi_i;
  logic        rsp_valid_o;
  logic [63:0] rsp_tdo_o;

  int tests = 0;
  int fails = 0;
  logic [1:0] capq[$];

  always #5 clk_i = ~clk_i;
  assign tdo_i = tdi_o;

  jtag_clk_rst_ctrl dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rst_no     (rst_no),
    .tck_o      (tck_o),
    .trst_no    (trst_no),
    .tms_o      (tms_o),
    .tdi_o      (tdi_o),
    .tdo_i      (tdo_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_reset_i(req_reset_i),
    .req_len_i  (req_len_i),
    .req_tms_i  (req_tms_i),
    .req_tdi_i  (req_tdi_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_tdo_o  (rsp_tdo_o)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic rr, input logic [6:0] len,
                      input logic [63:0] tms, input logic [63:0] tdi);
    int n;
    @(negedge clk_i);
    req_reset_i = rr;
    req_len_i   = len;
    req_tms_i   = tms;
    req_tdi_i   = tdi;
    req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("accept_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  // Model: bit i appears on the i-th TCK fall; TDO loopback returns
  // the TDI vector masked to min(len, 64) bits.
  task automatic run_shift(input logic [6:0] len, input logic [63:0] tms,
                           input logic [63:0] tdi, input bit inject);
    int eff, n, expcnt;
    logic prev;
    logic [63:0] mask, exp_tdo, got_tms, got_tdi;
    eff     = (len > 7'd64) ? 64 : int'(len);
    mask    = (eff >= 64) ? '1 : ((64'd1 << eff) - 64'd1);
    exp_tdo = tdi & mask;
    expcnt  = (eff == 0) ? 0 : eff + 1;
    capq.delete();
    send(1'b0, len, tms, tdi);
    @(negedge clk_i);
    prev = tck_o;
    n = 0;
    while (!rsp_valid_o && n < 2000) begin
      if (inject && n < 6) begin
        check("busy_ready", 64'(req_ready_o), 64'd0);
        req_valid_i = 1'b1;
        req_len_i   = 7'd3;
        req_tdi_i   = ~tdi;
        req_tms_i   = ~tms;
      end else begin
        req_valid_i = 1'b0;
      end
      @(negedge clk_i);
      n++;
      if (prev && !tck_o) capq.push_back({tms_o, tdi_o});
      prev = tck_o;
    end
    req_valid_i = 1'b0;
    check("rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("nbits", 64'(capq.size()), 64'(expcnt));
    if (capq.size() == expcnt && eff > 0) begin
      got_tms = '0;
      got_tdi = '0;
      for (int i = 0; i < eff; i++) begin
        got_tms[i] = capq[i][1];
        got_tdi[i] = capq[i][0];
      end
      check("tms_seq", got_tms, tms & mask);
      check("tdi_seq", got_tdi, exp_tdo);
      check("tail_zero", 64'(capq[eff]), 64'd0);
    end
    check("rsp_tdo", rsp_tdo_o, exp_tdo);
    @(negedge clk_i);
    check("valid_pulse", 64'(rsp_valid_o), 64'd0);
    check("tdo_hold", rsp_tdo_o, exp_tdo);
    check("idle_ready", 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    int n, toggles, low, exitc, badtms, seen;
    logic prev;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_reset_i = 1'b0;
    req_len_i   = '0;
    req_tms_i   = '0;
    req_tdi_i   = '0;

    repeat (3) @(negedge clk_i);
    check("rst_pins", 64'({rst_no, tck_o, trst_no, tms_o, tdi_o,
                          req_ready_o, rsp_valid_o}), 64'd0);
    check("rst_tdo", rsp_tdo_o, 64'd0);
    rst_i = 1'b0;
    n = 0;
    while (n < 50) begin
      @(posedge clk_i);
      n++;
      #1;
      if (rst_no) break;
    end
    check("rst_delay", 64'(n), 64'd5);
    @(negedge clk_i);
    prev = tck_o;
    toggles = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (tck_o !== prev) toggles++;
      prev = tck_o;
    end
    check("tck_toggle", 64'(toggles), 64'd8);
    check("idle_pins", 64'({trst_no, tms_o, tdi_o, req_ready_o}),
          64'b1001);

    run_shift(7'd5, 64'h10, 64'h15, 1'b0);
    run_shift(7'd0, '1, '1, 1'b0);
    run_shift(7'd100, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
              1'b0);
    run_shift(7'd64, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0003,
              1'b0);
    run_shift(7'd9, 64'h1a5, 64'h0f3, 1'b1);
    for (int k = 0; k < 8; k++)
      run_shift(7'($urandom_range(0, 100)), {$urandom, $urandom},
                {$urandom, $urandom}, 1'b0);

    send(1'b1, 7'd0, '0, '0);
    low = 0;
    exitc = 0;
    badtms = 0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (rsp_valid_o) break;
      if (!trst_no) begin
        low++;
        if (!tms_o) badtms++;
      end else if (low > 0) begin
        exitc++;
        if (tms_o) badtms++;
      end
    end
    check("trst_valid", 64'(rsp_valid_o), 64'd1);
    check("trst_low", 64'(low), 64'd10);
    check("tlr_exit", 64'(exitc), 64'd2);
    check("trst_tms", 64'(badtms), 64'd0);
    check("trst_tdo", rsp_tdo_o, 64'd0);

    send(1'b0, 7'd40, '1, '1);
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("abort_pins", 64'({rst_no, tck_o, trst_no, tms_o, tdi_o,
                            req_ready_o, rsp_valid_o}), 64'd0);
    check("abort_tdo", rsp_tdo_o, 64'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen++;
    end
    rst_i = 1'b0;
    n = 0;
    while (!rst_no && n < 50) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen++;
      n++;
    end
    check("abort_norsp", 64'(seen), 64'd0);
    check("abort_rst_no", 64'(rst_no), 64'd1);
    run_shift(7'd12, 64'h5a5, 64'hc3c, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
